// File: rtl/spi_receptor.sv
// spi_receptor: SPI slave, all four CKP/CPH modes, oversampled by CLK through 2-flop synchronizers.
// Back-to-back bytes under one CS; a mid-byte CS release aborts the byte.
module spi_receptor (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CKP,
    input  logic       CPH,
    input  logic       SCK,
    input  logic       CS,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       abort
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     r_state, w_next;
    logic       r_sck_s1, r_sck_s2, r_sck_s3;
    logic       r_cs_s1, r_cs_s2, r_cs_s3;
    logic       r_mosi_s1, r_mosi_s2;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_rx, r_tx, r_data_out;
    logic       r_skip;
    logic       w_sck_edge, w_lead, w_trail, w_sample, w_shift;
    logic       w_cs_fall, w_cs_rise, w_last, w_do_shift, w_abort;
    logic [7:0] w_rx_next;

    assign w_sck_edge = r_sck_s2 ^ r_sck_s3;
    assign w_lead     = w_sck_edge & (r_sck_s3 == CKP);
    assign w_trail    = w_sck_edge & (r_sck_s2 == CKP);
    assign w_sample   = CPH ? w_trail : w_lead;
    assign w_shift    = CPH ? w_lead : w_trail;
    assign w_cs_fall  = r_cs_s3 & ~r_cs_s2;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;
    // The 8th sample completes the byte even if CS rises in the same cycle
    assign w_last     = (r_state == SHIFT) && w_sample && (r_bit_cnt == 4'd7);
    assign w_rx_next  = {r_rx[6:0], r_mosi_s2};
    assign w_do_shift = (r_state == SHIFT) && w_shift && !r_skip && !w_cs_rise;

    // Look ahead one bit on a shift edge so MISO settles within half an SCK period
    assign MISO       = (r_state == IDLE) ? 1'b0 : (w_do_shift ? r_tx[6] : r_tx[7]);
    assign data_out   = r_data_out;
    assign data_valid = (r_state == DONE);
    assign abort      = w_abort;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= {3{CKP}};
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= 3'b111;
            {r_mosi_s1, r_mosi_s2}         <= 2'b00;
        end else begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= {SCK, r_sck_s1, r_sck_s2};
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= {CS, r_cs_s1, r_cs_s2};
            {r_mosi_s1, r_mosi_s2}         <= {MOSI, r_mosi_s1};
        end
    end

    always_ff @(posedge CLK) begin
        r_state <= RESET ? IDLE : w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:  w_next = w_cs_fall ? SHIFT : IDLE;
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end else if (w_cs_rise) begin
                    w_next  = IDLE;
                    w_abort = (r_bit_cnt != 4'd0);
                end
            end
            DONE:    w_next = r_cs_s2 ? IDLE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    // r_skip suppresses the first shift edge of each byte so bit 7 is not lost
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_bit_cnt  <= 4'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_data_out <= 8'h00;
            r_skip     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_tx      <= data_in;
                        r_bit_cnt <= 4'd0;
                        r_skip    <= CPH;
                    end
                end
                SHIFT: begin
                    if (w_sample && (w_last || !w_cs_rise)) begin
                        r_rx      <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    if (w_last)
                        r_data_out <= w_rx_next;
                    if (w_shift && !w_cs_rise) begin
                        if (r_skip)
                            r_skip <= 1'b0;
                        else
                            r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
                DONE: begin
                    r_bit_cnt <= 4'd0;
                    r_tx      <= data_in;
                    r_skip    <= 1'b1;
                end
                default: r_bit_cnt <= 4'd0;
            endcase
        end
    end
endmodule
